// File: rtl/axil_data_ram_pkg.sv
// Shared AXI4-Lite definitions for the core's data-memory path.
package axil_data_ram_pkg;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExokay = 2'b01,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } axi_resp_e;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/axil_data_ram_if.sv
// AXI4-Lite data-memory channels between the load/store unit (master) and the data RAM (slave).
interface axil_data_ram_if #(
    parameter int XLEN = 32,
    parameter int STRB = XLEN / 8
);
    logic                           ar_vld;
    logic                           ar_rdy;
    logic [XLEN-1:0]                ar_addr;
    logic [2:0]                     ar_prot;

    logic                           r_vld;
    logic                           r_rdy;
    logic [XLEN-1:0]                r_dat;
    axil_data_ram_pkg::axi_resp_e   r_resp;

    logic                           aw_vld;
    logic                           aw_rdy;
    logic [XLEN-1:0]                aw_addr;
    logic [2:0]                     aw_prot;

    logic                           w_vld;
    logic                           w_rdy;
    logic [XLEN-1:0]                w_dat;
    logic [STRB-1:0]                w_strb;

    logic                           b_vld;
    logic                           b_rdy;
    axil_data_ram_pkg::axi_resp_e   b_resp;

    modport master (
        output ar_vld, ar_addr, ar_prot, r_rdy,
        output aw_vld, aw_addr, aw_prot, w_vld, w_dat, w_strb, b_rdy,
        input  ar_rdy, r_vld, r_dat, r_resp,
        input  aw_rdy, w_rdy, b_vld, b_resp
    );

    modport slave (
        input  ar_vld, ar_addr, ar_prot, r_rdy,
        input  aw_vld, aw_addr, aw_prot, w_vld, w_dat, w_strb, b_rdy,
        output ar_rdy, r_vld, r_dat, r_resp,
        output aw_rdy, w_rdy, b_vld, b_resp
    );

endinterface

// File: rtl/axil_data_ram_byte_ram.sv
// Simple dual-port word RAM with per-byte write enables.
// Latency: read data registered, valid the cycle after rd_en; output holds while rd_en is low.
// Backpressure: none; a same-cycle read and write to one word returns the old contents.
module axil_data_ram_byte_ram
    import axil_data_ram_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 1024,
    localparam int STRB  = XLEN / BYTE_W,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [XLEN-1:0]  rd_dat,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [STRB-1:0]  wr_be,
    input  logic [XLEN-1:0]  wr_dat
);

    logic [XLEN-1:0] mem [DEPTH];

    // Both ports in one process: the non-blocking read samples the pre-write word.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_dat <= mem[rd_idx];
        end
        for (int b = 0; b < STRB; b++) begin
            if (wr_en && wr_be[b]) begin
                mem[wr_idx][b*BYTE_W +: BYTE_W] <= wr_dat[b*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/axil_data_ram.sv
// AXI4-Lite responder for the core's data memory: word reads, byte-strobed writes, OKAY/SLVERR.
// Latency: read data 1 cycle after AR; write response 2 cycles after the later of AW/W.
// Backpressure: single-entry R and B slots; AR stalls on a full R slot, AW/W capture stalls until B drains.
module axil_data_ram
    import axil_data_ram_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              STRB      = XLEN / 8,
    parameter int              DEPTH     = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst,
    axil_data_ram_if.slave  dm
);

    localparam int              IDX_W = $clog2(DEPTH);
    localparam logic [XLEN-1:0] SPAN  = XLEN'(DEPTH * STRB);

    // ---------------- read path ----------------
    logic            r_vld_q;
    logic            r_zero_q;
    axi_resp_e       r_resp_q;
    logic [XLEN-1:0] ram_rd_dat;
    logic [XLEN-1:0] ar_off;
    logic            ar_hit;
    logic            ar_hs;

    assign ar_off    = dm.ar_addr - BASE_ADDR;
    assign ar_hit    = (ar_off < SPAN);
    assign dm.ar_rdy = ~r_vld_q | dm.r_rdy;
    assign ar_hs     = dm.ar_vld & dm.ar_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_q  <= 1'b0;
            r_zero_q <= 1'b1;
            r_resp_q <= RespOkay;
        end else if (ar_hs) begin
            r_vld_q  <= 1'b1;
            r_zero_q <= ~ar_hit;
            r_resp_q <= ar_hit ? RespOkay : RespSlverr;
        end else if (dm.r_rdy) begin
            r_vld_q  <= 1'b0;
        end
    end

    // The RAM output register holds between reads; r_zero_q masks it after reset and on decode errors.
    assign dm.r_vld  = r_vld_q;
    assign dm.r_dat  = r_zero_q ? '0 : ram_rd_dat;
    assign dm.r_resp = r_resp_q;

    // ---------------- write path ----------------
    logic            aw_full;
    logic            w_full;
    logic [XLEN-1:0] aw_addr_q;
    logic [XLEN-1:0] w_dat_q;
    logic [STRB-1:0] w_strb_q;
    logic            b_vld_q;
    axi_resp_e       b_resp_q;
    logic [XLEN-1:0] aw_off;
    logic            aw_hit;
    logic            aw_hs;
    logic            w_hs;
    logic            commit;

    assign dm.aw_rdy = ~aw_full;
    assign dm.w_rdy  = ~w_full;
    assign aw_hs     = dm.aw_vld & ~aw_full;
    assign w_hs      = dm.w_vld & ~w_full;
    assign aw_off    = aw_addr_q - BASE_ADDR;
    assign aw_hit    = (aw_off < SPAN);
    assign commit    = aw_full & w_full & (~b_vld_q | dm.b_rdy);

    // A capture slot cannot be refilled in its commit cycle since its ready is low while full.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            b_vld_q  <= 1'b0;
            b_resp_q <= RespOkay;
        end else begin
            if (aw_hs) begin
                aw_full <= 1'b1;
            end else if (commit) begin
                aw_full <= 1'b0;
            end

            if (w_hs) begin
                w_full <= 1'b1;
            end else if (commit) begin
                w_full <= 1'b0;
            end

            if (commit) begin
                b_vld_q  <= 1'b1;
                b_resp_q <= aw_hit ? RespOkay : RespSlverr;
            end else if (dm.b_rdy) begin
                b_vld_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) begin
            aw_addr_q <= dm.aw_addr;
        end
        if (w_hs) begin
            w_dat_q  <= dm.w_dat;
            w_strb_q <= dm.w_strb;
        end
    end

    assign dm.b_vld  = b_vld_q;
    assign dm.b_resp = b_resp_q;

    axil_data_ram_byte_ram #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_byte_ram (
        .clk    (clk),
        .rd_en  (ar_hs),
        .rd_idx (ar_off[IDX_W+1:2]),
        .rd_dat (ram_rd_dat),
        .wr_en  (commit & aw_hit),
        .wr_idx (aw_off[IDX_W+1:2]),
        .wr_be  (w_strb_q),
        .wr_dat (w_dat_q)
    );

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{dm.ar_prot, dm.aw_prot, ar_off, aw_off};

endmodule

// File: tb/tb_axil_data_ram.sv
// Directed bench for axil_data_ram: vector table plus hand-written handshake and timing sequences.
module tb_axil_data_ram;
    import axil_data_ram_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axil_data_ram_if #(.XLEN(32)) dm_if ();

    axil_data_ram #(
        .XLEN      (32),
        .DEPTH     (1024),
        .BASE_ADDR (32'h0000_0000)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .dm  (dm_if)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_dat;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[18];
    int   total = 0;
    int   bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_hit, w_hit;
        int n = 0;
        dm_if.aw_vld  = 1'b1;
        dm_if.aw_addr = a;
        dm_if.w_vld   = 1'b1;
        dm_if.w_dat   = d;
        dm_if.w_strb  = s;
        dm_if.b_rdy   = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hit = dm_if.aw_vld && dm_if.aw_rdy;
            w_hit  = dm_if.w_vld && dm_if.w_rdy;
            tick();
            if (aw_hit) begin aw_done = 1'b1; dm_if.aw_vld = 1'b0; end
            if (w_hit)  begin w_done  = 1'b1; dm_if.w_vld  = 1'b0; end
            n++;
        end
        dm_if.aw_vld = 1'b0;
        dm_if.w_vld  = 1'b0;
        n = 0;
        while (!dm_if.b_vld && n < 20) begin
            tick();
            n++;
        end
        check("wr_b_arrives", 32'(dm_if.b_vld), 32'd1);
        resp = dm_if.b_resp;
        tick();
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit hit;
        bit done = 1'b0;
        int n = 0;
        dm_if.ar_vld  = 1'b1;
        dm_if.ar_addr = a;
        dm_if.r_rdy   = 1'b0;
        while (!done && n < 20) begin
            hit = dm_if.ar_vld && dm_if.ar_rdy;
            tick();
            if (hit) done = 1'b1;
            n++;
        end
        dm_if.ar_vld = 1'b0;
        check("rd_r_arrives", 32'(dm_if.r_vld), 32'd1);
        d    = dm_if.r_dat;
        resp = dm_if.r_resp;
        dm_if.r_rdy = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        int          nb;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
        vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0,         2'b00};
        vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0,         2'b00};
        vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 2'b00};
        vecs[5]  = '{1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'hF, 32'h0,         2'b00};
        vecs[6]  = '{1'b1, 32'h0000_0024, 32'h0000_0000, 4'h0, 32'h0,         2'b00};
        vecs[7]  = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'hCAFE_F00D, 2'b00};
        vecs[8]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 32'h0,         2'b00};
        vecs[9]  = '{1'b1, 32'h0000_0004, 32'h0000_0044, 4'hF, 32'h0,         2'b00};
        vecs[10] = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0,         2'b10};
        vecs[11] = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b10};
        vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h1234_5678, 2'b00};
        vecs[13] = '{1'b0, 32'h0000_0013, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
        vecs[14] = '{1'b1, 32'h0000_0FFC, 32'h0BAD_CAFE, 4'hF, 32'h0,         2'b00};
        vecs[15] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h0BAD_CAFE, 2'b00};
        vecs[16] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0,         2'b10};
        vecs[17] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'h0000_0044, 2'b00};

        rst           = 1'b1;
        dm_if.ar_vld  = 1'b0;
        dm_if.ar_addr = '0;
        dm_if.ar_prot = 3'b000;
        dm_if.r_rdy   = 1'b1;
        dm_if.aw_vld  = 1'b0;
        dm_if.aw_addr = '0;
        dm_if.aw_prot = 3'b111;
        dm_if.w_vld   = 1'b0;
        dm_if.w_dat   = '0;
        dm_if.w_strb  = '0;
        dm_if.b_rdy   = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // reset state
        check("rst_r_vld",  32'(dm_if.r_vld),  32'd0);
        check("rst_b_vld",  32'(dm_if.b_vld),  32'd0);
        check("rst_ar_rdy", 32'(dm_if.ar_rdy), 32'd1);
        check("rst_aw_rdy", 32'(dm_if.aw_rdy), 32'd1);
        check("rst_w_rdy",  32'(dm_if.w_rdy),  32'd1);
        check("rst_r_dat",  dm_if.r_dat,       32'd0);
        check("rst_r_resp", 32'(dm_if.r_resp), 32'd0);
        check("rst_b_resp", 32'(dm_if.b_resp), 32'd0);

        // write latency: AW+W together, bvalid two cycles later; read data one cycle after AR
        dm_if.aw_vld = 1'b1; dm_if.aw_addr = 32'h10;
        dm_if.w_vld  = 1'b1; dm_if.w_dat = 32'hDEAD_BEEF; dm_if.w_strb = 4'hF;
        tick();
        dm_if.aw_vld = 1'b0; dm_if.w_vld = 1'b0;
        check("lat_aw_rdy_low", 32'(dm_if.aw_rdy), 32'd0);
        check("lat_b_n1",       32'(dm_if.b_vld),  32'd0);
        tick();
        check("lat_b_n2",  32'(dm_if.b_vld),  32'd1);
        check("lat_bresp", 32'(dm_if.b_resp), 32'd0);
        tick();
        check("lat_b_drained", 32'(dm_if.b_vld), 32'd0);
        dm_if.ar_vld = 1'b1; dm_if.ar_addr = 32'h10;
        tick();
        dm_if.ar_vld = 1'b0;
        check("lat_r_vld",  32'(dm_if.r_vld),  32'd1);
        check("lat_r_dat",  dm_if.r_dat,       32'hDEAD_BEEF);
        check("lat_r_resp", 32'(dm_if.r_resp), 32'd0);
        tick();
        check("lat_r_drained", 32'(dm_if.r_vld), 32'd0);

        // vector table
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, rs);
                check($sformatf("vec%0d_bresp", i), 32'(rs), 32'(vecs[i].exp_resp));
            end else begin
                do_read(vecs[i].addr, rd, rs);
                check($sformatf("vec%0d_rdat", i),  rd,      vecs[i].exp_dat);
                check($sformatf("vec%0d_rresp", i), 32'(rs), 32'(vecs[i].exp_resp));
            end
        end

        // W two cycles ahead of AW
        dm_if.w_vld = 1'b1; dm_if.w_dat = 32'h5; dm_if.w_strb = 4'hF;
        tick();
        dm_if.w_vld = 1'b0;
        check("wfirst_w_rdy_low", 32'(dm_if.w_rdy), 32'd0);
        tick();
        tick();
        check("wfirst_no_b",   32'(dm_if.b_vld), 32'd0);
        check("wfirst_w_held", 32'(dm_if.w_rdy), 32'd0);
        dm_if.aw_vld = 1'b1; dm_if.aw_addr = 32'h30;
        tick();
        dm_if.aw_vld = 1'b0;
        nb = 0;
        repeat (5) begin
            if (dm_if.b_vld) nb++;
            tick();
        end
        check("wfirst_one_b", 32'(nb), 32'd1);
        do_read(32'h30, rd, rs);
        check("wfirst_rdat", rd, 32'h5);

        // read-first when AR and a commit hit the same word in one cycle
        do_write(32'h60, 32'h0000_600D, 4'hF, rs);
        dm_if.aw_vld = 1'b1; dm_if.aw_addr = 32'h60;
        dm_if.w_vld  = 1'b1; dm_if.w_dat = 32'hBEEF_0060; dm_if.w_strb = 4'hF;
        tick();
        dm_if.aw_vld = 1'b0; dm_if.w_vld = 1'b0;
        dm_if.ar_vld = 1'b1; dm_if.ar_addr = 32'h60; dm_if.r_rdy = 1'b1;
        tick();
        dm_if.ar_vld = 1'b0;
        check("rfirst_old_dat", dm_if.r_dat,      32'h0000_600D);
        check("rfirst_b_vld",   32'(dm_if.b_vld), 32'd1);
        tick();
        do_read(32'h60, rd, rs);
        check("rfirst_new_dat", rd, 32'hBEEF_0060);

        // read backpressure, then back-to-back beats
        dm_if.r_rdy = 1'b0;
        dm_if.ar_vld = 1'b1; dm_if.ar_addr = 32'h10;
        tick();
        dm_if.ar_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("rbp_r_vld",  32'(dm_if.r_vld),  32'd1);
            check("rbp_r_dat",  dm_if.r_dat,       32'hDEAD_BEEF);
            check("rbp_ar_rdy", 32'(dm_if.ar_rdy), 32'd0);
            tick();
        end
        dm_if.r_rdy = 1'b1;
        dm_if.ar_vld = 1'b1; dm_if.ar_addr = 32'h0;
        tick();
        check("b2b_vld0", 32'(dm_if.r_vld), 32'd1);
        check("b2b_dat0", dm_if.r_dat,      32'h1234_5678);
        dm_if.ar_addr = 32'h4;
        tick();
        dm_if.ar_vld = 1'b0;
        check("b2b_vld1", 32'(dm_if.r_vld), 32'd1);
        check("b2b_dat1", dm_if.r_dat,      32'h0000_0044);
        tick();
        check("b2b_done", 32'(dm_if.r_vld), 32'd0);

        // write backpressure: second AW/W captured but held until B drains
        do_write(32'h44, 32'h77, 4'hF, rs);
        dm_if.b_rdy = 1'b0;
        dm_if.aw_vld = 1'b1; dm_if.aw_addr = 32'h40;
        dm_if.w_vld  = 1'b1; dm_if.w_dat = 32'h1; dm_if.w_strb = 4'hF;
        tick();
        dm_if.aw_vld = 1'b0; dm_if.w_vld = 1'b0;
        tick();
        tick();
        check("wbp_b_held",    32'(dm_if.b_vld),  32'd1);
        check("wbp_aw_rdy_ok", 32'(dm_if.aw_rdy), 32'd1);
        dm_if.aw_vld = 1'b1; dm_if.aw_addr = 32'h44;
        dm_if.w_vld  = 1'b1; dm_if.w_dat = 32'h2;
        tick();
        dm_if.aw_vld = 1'b0; dm_if.w_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("wbp_stall_aw_rdy", 32'(dm_if.aw_rdy), 32'd0);
            check("wbp_stall_w_rdy",  32'(dm_if.w_rdy),  32'd0);
            check("wbp_stall_b_vld",  32'(dm_if.b_vld),  32'd1);
            tick();
        end
        do_read(32'h44, rd, rs);
        check("wbp_not_committed", rd, 32'h77);
        dm_if.b_rdy = 1'b1;
        tick();
        check("wbp_second_b",   32'(dm_if.b_vld),  32'd1);
        check("wbp_second_rsp", 32'(dm_if.b_resp), 32'd0);
        check("wbp_aw_rdy_back",32'(dm_if.aw_rdy), 32'd1);
        tick();
        check("wbp_b_drained", 32'(dm_if.b_vld), 32'd0);
        do_read(32'h44, rd, rs);
        check("wbp_rd44", rd, 32'h2);
        do_read(32'h40, rd, rs);
        check("wbp_rd40", rd, 32'h1);

        // reset in the middle of a read beat and a half-captured write
        dm_if.r_rdy = 1'b0;
        dm_if.ar_vld = 1'b1; dm_if.ar_addr = 32'h10;
        dm_if.aw_vld = 1'b1; dm_if.aw_addr = 32'h50;
        tick();
        dm_if.ar_vld = 1'b0; dm_if.aw_vld = 1'b0;
        check("mid_aw_full", 32'(dm_if.aw_rdy), 32'd0);
        check("mid_r_vld",   32'(dm_if.r_vld),  32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_r_vld",  32'(dm_if.r_vld),  32'd0);
        check("mid_rst_b_vld",  32'(dm_if.b_vld),  32'd0);
        check("mid_rst_aw_rdy", 32'(dm_if.aw_rdy), 32'd1);
        check("mid_rst_w_rdy",  32'(dm_if.w_rdy),  32'd1);
        check("mid_rst_ar_rdy", 32'(dm_if.ar_rdy), 32'd1);
        check("mid_rst_r_dat",  dm_if.r_dat,       32'd0);
        tick();
        do_read(32'h10, rd, rs);
        check("mid_ram_kept", rd, 32'hDEAD_BEEF);
        tick();
        check("mid_no_b", 32'(dm_if.b_vld), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
